// File: rtl/five_bit_counter_pkg.sv
// Shared constants for the five-bit counter slice.
// Defaults for counter width and the value loaded on reset.
package five_bit_counter_pkg;

   localparam int unsigned CounterWidth      = 5;
   localparam int unsigned CounterResetValue = 0;

endpackage

// File: rtl/counter_reg.sv
// WIDTH-bit register with asynchronous active-low clear and synchronous load enable.
// The clear drives the register straight to RESET_VALUE with no other logic on the path.
module counter_reg #(
   parameter int unsigned WIDTH       = 5,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= WIDTH'(RESET_VALUE);
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/five_bit_counter.sv
// Free-running modulo-2^WIDTH up-counter with enable and an all-ones flag.
// The incrementer and the max compare live here; state is held in counter_reg.
module five_bit_counter
   import five_bit_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = CounterWidth,
   parameter int unsigned RESET_VALUE = CounterResetValue
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count_enable,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   logic [WIDTH-1:0] count_d;

   // WIDTH-bit add, so the carry out of the top bit is dropped and 31 wraps to 0.
   always_comb begin
      count_d = count + WIDTH'(1);
      at_max  = (count == {WIDTH{1'b1}});
   end

   counter_reg #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_counter_reg (
      .clk   (clk),
      .rst_n (reset),
      .en    (count_enable),
      .d     (count_d),
      .q     (count)
   );

endmodule

// File: tb/tb_five_bit_counter.sv
// Self-checking bench for five_bit_counter: a table of per-cycle vectors plus
// hand-written sequences for mid-cycle reset and alternating enable.
module tb_five_bit_counter;

   typedef struct {
      logic       rst;
      logic       en;
      logic [4:0] exp_count;
      logic       exp_max;
      string      tag;
   } vec_t;

   typedef struct {
      logic [4:0] exp_count;
      logic       exp_max;
      string      tag;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       count_enable;
   logic [4:0] count;
   logic       at_max;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   exp_t exp_q[$];

   five_bit_counter dut (
      .clk          (clk),
      .reset        (reset),
      .count_enable (count_enable),
      .count        (count),
      .at_max       (at_max)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Drive between edges, queue the expectation, compare just after the next rising edge.
   task automatic apply(input logic rst, input logic en, input logic [4:0] ec,
                        input logic em, input string tag);
      exp_t e;
      @(negedge clk);
      reset        = rst;
      count_enable = en;
      exp_q.push_back('{ec, em, tag});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({e.tag, ".count"}, 32'(count), 32'(e.exp_count));
      check({e.tag, ".at_max"}, 32'(at_max), 32'(e.exp_max));
   endtask

   initial begin
      clk          = 1'b0;
      reset        = 1'b0;
      count_enable = 1'b0;
      #1;
      check("reset_state.count", 32'(count), 32'd0);
      check("reset_state.at_max", 32'(at_max), 32'd0);

      for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b0, 5'd0, 1'b0, "reset_hold"});
      for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 1'b1, 5'd0, 1'b0, "reset_ignores_en"});
      vecs.push_back('{1'b1, 1'b0, 5'd0, 1'b0, "release_idle"});
      for (int i = 0; i < 20; i++) vecs.push_back('{1'b1, 1'b1, 5'(i + 1), 1'b0, "count_up"});
      for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 1'b0, 5'd20, 1'b0, "hold_20"});
      for (int v = 21; v <= 31; v++) vecs.push_back('{1'b1, 1'b1, 5'(v), (v == 31), "resume"});
      for (int v = 0; v <= 3; v++) vecs.push_back('{1'b1, 1'b1, 5'(v), 1'b0, "wrap"});

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].en, vecs[i].exp_count, vecs[i].exp_max,
               $sformatf("%s[%0d]", vecs[i].tag, i));
      end

      // Mid-cycle asynchronous reset at count=7.
      apply(1'b0, 1'b0, 5'd0, 1'b0, "pre7_reset");
      for (int i = 1; i <= 7; i++) apply(1'b1, 1'b1, 5'(i), 1'b0, $sformatf("to7[%0d]", i));
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset.count", 32'(count), 32'd0);
      check("async_reset.at_max", 32'(at_max), 32'd0);
      @(posedge clk);
      #1;
      check("async_reset_held.count", 32'(count), 32'd0);
      apply(1'b1, 1'b1, 5'd1, 1'b0, "post_reset_first");

      // Alternating enable from zero: ten cycles give five increments.
      apply(1'b0, 1'b0, 5'd0, 1'b0, "toggle_reset");
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, (i % 2 == 0), 5'(i / 2 + 1), 1'b0, $sformatf("toggle[%0d]", i));
      end
      check("toggle_final.count", 32'(count), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/five_bit_counter.md
FIVE_BIT_COUNTER -- requirements
Module: five_bit_counter

Interface
REQ-001 Parameter WIDTH, default 5, counter width in bits; the block SHALL be verified at the default only.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into count by reset; SHALL fit in WIDTH bits.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port count_enable, input, 1, active-high increment request, sampled on rising clk.
REQ-006 Port count, output, WIDTH, current counter value, driven directly from a register.
REQ-007 Port at_max, output, 1, combinational flag: high when count equals 2^WIDTH-1 (31).

Function
REQ-008 On a rising clk with reset high and count_enable high, count SHALL become count+1 modulo 2^WIDTH.
REQ-009 On a rising clk with reset high and count_enable low, count SHALL hold its value.
REQ-010 Increment latency SHALL be one cycle: the new value is visible after the same edge that samples count_enable=1.
REQ-011 Wrap-around: count=31 with count_enable=1 SHALL produce count=0 on the next edge, with no saturation and no error flag.
REQ-012 at_max SHALL be 1 only while count=31 and SHALL follow count with no added latency.
REQ-013 count SHALL never be X or Z after the first reset assertion; increment arithmetic SHALL be WIDTH bits wide, with the carry discarded.
REQ-014 count_enable held high continuously SHALL produce one increment per clock with no skipped or repeated values.

Reset
REQ-015 When reset goes low, count SHALL take RESET_VALUE (0) immediately, independent of clk.
REQ-016 While reset is low, count SHALL stay at RESET_VALUE regardless of count_enable or clk; at_max SHALL be 0 at the default RESET_VALUE.
REQ-017 Reset asserted mid-count SHALL discard the current value; no partial state SHALL survive.
REQ-018 Counting SHALL resume on the first rising clk after reset returns high with count_enable=1, and that edge SHALL produce RESET_VALUE+1.

Structure
REQ-019 WIDTH default and RESET_VALUE default SHALL be defined in the shared counter package as constants; no typedefs are required.
REQ-020 One sub-module SHALL be used: counter_reg, a WIDTH-bit register with asynchronous active-low clear and synchronous enable; five_bit_counter SHALL contain the incrementer and the at_max compare.
REQ-021 The block SHALL contain no latches, no gated clocks, and no logic on the reset path other than direct register clear.

Verification
REQ-022 Hold reset low for 10 cycles with count_enable=0, then release it -> count=0 and at_max=0 throughout.
REQ-023 Release reset, set count_enable=1 for 20 cycles -> count SHALL step 1,2,...,20, one step per edge.
REQ-024 Drop count_enable for 5 cycles at count=20 -> count SHALL hold at 20, then resume at 21 when count_enable returns to 1.
REQ-025 Count continuously from 25 for 10 edges -> count SHALL read 26..31, then 0,1,2,3; at_max SHALL be high only while count=31.
REQ-026 Assert reset low between clock edges while count=7 -> count SHALL be 0 before the next edge; after release with count_enable=1, the first edge SHALL give count=1.
REQ-027 Toggle count_enable every cycle from count=0 for 10 cycles -> count SHALL end at 5.
